bcd_display_scan: RTL
=====================

# bcd_display_scan

Two-digit time-multiplexed scan controller for the 7-segment path. It accepts the 8-bit BCD pair produced by the binary-to-BCD converter, holds it in a frame-stable display register, and presents one digit nibble at a time to the BCD-to-segment decoder. It also drives the active-low digit anodes, inserts a one-cycle dead time between digits against ghosting, and applies leading-zero and invalid-digit blanking.

## Interface
- DIV_WIDTH, 16: refresh divider width. Each digit slot lasts 2^DIV_WIDTH cycles. Legal range is ≥2.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- bcd_in  input  8  [7:4] tens nibble, [3:0] units nibble.
- load  input  1  single-cycle request to capture bcd_in for display.
- blank_lz  input  1  enables leading-zero blanking of the tens digit.
- digit_out  output  4  nibble routed to the segment decoder.
- blank  output  1  high forces segments off for the current slot.
- an  output  2  active-low anodes: an[0] drives units, an[1] drives tens.
- frame_done  output  1  one-cycle pulse at each frame boundary.
- upd_pending  output  1  a loaded value is waiting for the frame boundary.
- err  output  1  the display register holds a nibble > 9.

## Operation
- Refresh counter cnt[DIV_WIDTH-1:0] free-runs and wraps. tick = (cnt == all ones).
- The FSM has four states: UNITS, DEAD_U2T, TENS, DEAD_T2U.
  - UNITS goes to DEAD_U2T on tick.
  - DEAD_U2T goes to TENS unconditionally after 1 cycle.
  - TENS goes to DEAD_T2U on tick.
  - DEAD_T2U goes to UNITS unconditionally after 1 cycle.
- Outputs are decoded combinationally from the registered state and the display register disp[7:0]:
  - UNITS: an=2'b10, digit_out=disp[3:0].
  - TENS: an=2'b01, digit_out=disp[7:4].
  - DEAD_*: an=2'b11, blank=1, digit_out=0.
- Blanking rules:
  - Tens slot: blank=1 if (blank_lz && disp[7:4]==0) or disp[7:4]>9.
  - Units slot: blank=1 only if disp[3:0]>9. Units is never blanked for leading zero.
- Load path:
  - load=1 writes pend<=bcd_in and sets upd_pending.
  - Repeated loads before a boundary overwrite pend; last one wins.
- Frame boundary is the DEAD_T2U cycle. frame_done=1 in that cycle only. On its closing edge:
  - If load=1 in that same cycle, disp<=bcd_in directly (bypass) and upd_pending clears.
  - Otherwise, if upd_pending, disp<=pend and upd_pending clears.
  - Otherwise disp holds.
- disp never changes outside the boundary edge. No digit pair is ever shown torn.
- err = (disp[7:4]>9) || (disp[3:0]>9). It is combinational on disp, so it updates only at boundaries.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-frame or mid-load):
  - Registers: cnt=0, state=UNITS, disp=8'h00, pend=8'h00, upd_pending=0.
  - Outputs: an=2'b10, digit_out=0, blank=0, frame_done=0, err=0.
- With P=2^DIV_WIDTH, if tick occurs at cycle t in UNITS:
  - DEAD_U2T at t+1, TENS at t+2.
  - The next tick is at t+P, then DEAD_T2U at t+P+1, then UNITS at t+P+2.
  - Each digit is lit P−1 cycles. Frame period is exactly 2P cycles.
- First tick after reset release occurs at cycle P−1 (cnt counts from 0).
- Load-to-display latency is variable: from 1 cycle (load in DEAD_T2U) up to 2P cycles. upd_pending is visible the cycle after load.
- A tick can never coincide with a DEAD state, because cnt advances every cycle and DIV_WIDTH≥2.

## Test plan
- DIV_WIDTH=2, reset then idle:
  - an sequence is 10,10,10,11,01,01,01,11, repeating every 8 cycles.
  - frame_done pulses on every 11 that precedes 10.
  - digit_out=0 throughout; blank=0 in units slots.
- Load 8'h47 mid-TENS:
  - upd_pending=1 next cycle.
  - disp changes only after the next DEAD_T2U.
  - Units slot then shows digit_out=7, tens slot digit_out=4.
  - upd_pending=0 from the boundary onward.
- Load 8'h05 with blank_lz=1:
  - Tens slot has blank=1, an=2'b01.
  - Units slot shows 5 with blank=0.
  - With blank_lz=0, tens shows 0 unblanked.
- Load 8'h3C:
  - After the boundary, err=1 and the units slot is blanked; tens shows 3.
  - A following load of 8'h12 clears err at the next boundary.
- Simultaneous events:
  - Load 8'h11 in TENS, then load 8'h99 in the DEAD_T2U cycle: disp=8'h99 after the boundary (bypass wins).
  - Two loads 8'h21 then 8'h34 in one frame: disp=8'h34.
- Mid-frame reset:
  - Assert rst_n=0 during TENS with upd_pending=1: outputs immediately go to an=2'b10, digit_out=0, upd_pending=0, err=0.
  - After release, the first tick arrives at cycle P−1.

Source files
------------

// File: rtl/bcd_display_scan.sv
// Two-digit time-multiplexed 7-segment scan controller with frame-stable display
// register, dead time between digits, and leading-zero / invalid-digit blanking.
`timescale 1ns/1ps

module bcd_display_scan #(
   parameter int DIV_WIDTH = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] bcd_in,
   input  logic       load,
   input  logic       blank_lz,
   output logic [3:0] digit_out,
   output logic       blank,
   output logic [1:0] an,
   output logic       frame_done,
   output logic       upd_pending,
   output logic       err
);

   typedef enum logic [1:0] {
      UNITS    = 2'd0,
      DEAD_U2T = 2'd1,
      TENS     = 2'd2,
      DEAD_T2U = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
   logic [7:0]           disp_q, disp_d;
   logic [7:0]           pend_q, pend_d;
   logic                 pending_q, pending_d;
   logic                 tick;
   logic                 boundary;

   assign tick     = &cnt_q;
   assign boundary = (state_q == DEAD_T2U);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         UNITS:    if (tick) state_d = DEAD_U2T;
         DEAD_U2T: state_d = TENS;
         TENS:     if (tick) state_d = DEAD_T2U;
         DEAD_T2U: state_d = UNITS;
         default:  state_d = UNITS;
      endcase
   end

   // The display register only moves on the frame-boundary edge so a digit
   // pair is never shown torn; a load in that same cycle bypasses pend.
   always_comb begin
      cnt_d     = cnt_q + 1'b1;
      disp_d    = disp_q;
      pend_d    = pend_q;
      pending_d = pending_q;
      if (load) begin
         pend_d    = bcd_in;
         pending_d = 1'b1;
      end
      if (boundary) begin
         if (load) begin
            disp_d    = bcd_in;
            pending_d = 1'b0;
         end else if (pending_q) begin
            disp_d    = pend_q;
            pending_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         state_q   <= UNITS;
         disp_q    <= 8'h00;
         pend_q    <= 8'h00;
         pending_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         state_q   <= state_d;
         disp_q    <= disp_d;
         pend_q    <= pend_d;
         pending_q <= pending_d;
      end
   end

   always_comb begin
      an        = 2'b11;
      digit_out = 4'd0;
      blank     = 1'b1;
      unique case (state_q)
         UNITS: begin
            an        = 2'b10;
            digit_out = disp_q[3:0];
            blank     = (disp_q[3:0] > 4'd9);
         end
         TENS: begin
            an        = 2'b01;
            digit_out = disp_q[7:4];
            blank     = (blank_lz && (disp_q[7:4] == 4'd0)) || (disp_q[7:4] > 4'd9);
         end
         default: begin
            an        = 2'b11;
            digit_out = 4'd0;
            blank     = 1'b1;
         end
      endcase
   end

   assign frame_done  = boundary;
   assign upd_pending = pending_q;
   assign err         = (disp_q[7:4] > 4'd9) || (disp_q[3:0] > 4'd9);

endmodule
